// File: rtl/lcd_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// lcd_cmd_seq_if
// Command/write-back bus between the command sequencer and the LCD image
// controller (plus the IRAM write-back stream it observes).
//   cmd        [3:0]  command code to controller
//   cmd_valid         single-cycle command strobe
//   busy              controller busy
//   done              controller write-back complete
//   IRAM_valid        write-back beat valid
//   IRAM_D     [7:0]  write-back data
//   IRAM_A     [5:0]  write-back address
// Modports: master = sequencer side, slave = controller/IRAM side.
// ---------------------------------------------------------------------------
interface lcd_cmd_seq_if;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;

  modport master (
    output cmd, cmd_valid,
    input  busy, done, IRAM_valid, IRAM_D, IRAM_A
  );

  modport slave (
    input  cmd, cmd_valid,
    output busy, done, IRAM_valid, IRAM_D, IRAM_A
  );
endinterface

// File: rtl/lcd_cmd_seq.sv
// ---------------------------------------------------------------------------
// lcd_cmd_seq
// Command initiator for the LCD image controller. Host commands are queued in
// a small FIFO and issued one at a time as single-cycle cmd_valid strobes,
// honouring the controller busy flag and a minimum idle gap. A Write command
// (code 0) is followed by monitoring of the IRAM write-back stream, counting
// beats (saturating at 64) and summing data bytes modulo 2^14.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   host_cmd[3:0]     command code to enqueue (12..15 rejected)
//   host_push         enqueue strobe
//   fifo_full/empty   registered occupancy flags
//   ctl               lcd_cmd_seq_if.master (cmd, cmd_valid, busy, done, IRAM_*)
//   seq_idle          idle with nothing queued
//   wb_count[6:0]     beats in last/current write-back
//   wb_sum[13:0]      byte sum of those beats
//   seq_err           sticky error flag
//
// Optional feature macro: WB_ORDER_CHECK_EN
//   When defined, write-back beats must arrive with addresses 0,1,..,63;
//   an out-of-order address sets seq_err. When undefined IRAM_A is ignored.
// ---------------------------------------------------------------------------
module lcd_cmd_seq #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          host_cmd,
  input  logic                host_push,
  output logic                fifo_full,
  output logic                fifo_empty,
  lcd_cmd_seq_if.master       ctl,
  output logic                seq_idle,
  output logic [6:0]          wb_count,
  output logic [13:0]         wb_sum,
  output logic                seq_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [6:0]    WB_BEATS = 7'd64;

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WB
  } state_t;

  state_t        state;
  logic          saw_busy;
  logic [GW-1:0] gap_cnt;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;

  logic          code_ok;
  logic          pop_en;
  logic          push_en;
  logic          push_drop;
  logic          push_bad;
  logic          beat;
  logic [6:0]    cnt_beat;
  logic [13:0]   sum_beat;
  logic          wb_short;
  logic          order_err;

`ifdef WB_ORDER_CHECK_EN
  logic [5:0]    exp_addr;
`else
  logic          unused_iram_a;
  assign unused_iram_a = ^ctl.IRAM_A;
`endif

  always_comb begin
    code_ok   = (host_cmd < 4'd12);
    pop_en    = (state == S_IDLE) && (count != '0) && !ctl.busy;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    push_en   = host_push && code_ok && ((count != DEPTH_C) || pop_en);
    push_drop = host_push && code_ok && (count == DEPTH_C) && !pop_en;
    push_bad  = host_push && !code_ok;
    count_nxt = count + (AW+1)'(push_en) - (AW+1)'(pop_en);

    // Write-back accounting including a beat that lands in the current cycle,
    // so a beat coincident with done is part of the final tally.
    beat      = (state == S_WB) && ctl.IRAM_valid;
    cnt_beat  = wb_count;
    sum_beat  = wb_sum;
    if (beat) begin
      cnt_beat = (wb_count == WB_BEATS) ? WB_BEATS : wb_count + 7'd1;
      sum_beat = wb_sum + {6'd0, ctl.IRAM_D};
    end
    wb_short  = (state == S_WB) && ctl.done && (cnt_beat != WB_BEATS);
`ifdef WB_ORDER_CHECK_EN
    order_err = beat && (ctl.IRAM_A != exp_addr);
`else
    order_err = 1'b0;
`endif
  end

  // FIFO storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= host_cmd;
  end

  // FIFO pointers and registered flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nxt;
      fifo_full  <= (count_nxt == DEPTH_C);
      fifo_empty <= (count_nxt == '0);
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_BOOT;
      saw_busy      <= 1'b0;
      gap_cnt       <= '0;
      ctl.cmd       <= 4'd0;
      ctl.cmd_valid <= 1'b0;
      seq_idle      <= 1'b0;
      wb_count      <= '0;
      wb_sum        <= '0;
      seq_err       <= 1'b0;
`ifdef WB_ORDER_CHECK_EN
      exp_addr      <= '0;
`endif
    end else begin
      ctl.cmd_valid <= 1'b0;
      seq_idle      <= 1'b0;
      if (push_drop || push_bad || wb_short || order_err) seq_err <= 1'b1;

      case (state)
        // Image load: wait for busy to be seen high, then low again.
        S_BOOT: begin
          if (ctl.busy) begin
            saw_busy <= 1'b1;
          end else if (saw_busy) begin
            state    <= S_IDLE;
            seq_idle <= (count_nxt == '0);
          end
        end

        S_IDLE: begin
          if (pop_en) begin
            ctl.cmd       <= mem[rd_ptr];
            ctl.cmd_valid <= 1'b1;
            state         <= S_ISSUE;
          end else begin
            seq_idle <= (count_nxt == '0);
          end
        end

        S_ISSUE: begin
          if (ctl.cmd == 4'd0) begin
            state    <= S_WB;
            wb_count <= '0;
            wb_sum   <= '0;
`ifdef WB_ORDER_CHECK_EN
            exp_addr <= '0;
`endif
          end else begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= S_IDLE;
            seq_idle <= (count_nxt == '0);
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        S_WB: begin
          wb_count <= cnt_beat;
          wb_sum   <= sum_beat;
`ifdef WB_ORDER_CHECK_EN
          if (beat) exp_addr <= exp_addr + 6'd1;
`endif
          if (ctl.done) begin
            state    <= S_IDLE;
            seq_idle <= (count_nxt == '0);
          end
        end

        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_seq
// Directed bench for lcd_cmd_seq. Issued commands are queued as expectations
// when pushed; a monitor pops and compares on every cmd_valid strobe and also
// checks pulse width and inter-pulse spacing.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_seq;
  localparam int FIFO_DEPTH = 16;
  localparam int GAP_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  host_cmd = 4'd0;
  logic        host_push = 1'b0;
  logic        fifo_full;
  logic        fifo_empty;
  logic        seq_idle;
  logic [6:0]  wb_count;
  logic [13:0] wb_sum;
  logic        seq_err;

  lcd_cmd_seq_if bus();

  lcd_cmd_seq #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_push  (host_push),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .ctl        (bus),
    .seq_idle   (seq_idle),
    .wb_count   (wb_count),
    .wb_sum     (wb_sum),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_q[$];

`ifdef WB_ORDER_CHECK_EN
  localparam logic ORDER_ERR_EXP = 1'b1;
`else
  localparam logic ORDER_ERR_EXP = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c, input bit will_issue);
    if (will_issue) exp_q.push_back(c);
    host_cmd  = c;
    host_push = 1'b1;
    tick();
    host_push = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    reset = 1'b0;
    tick();
  endtask

  task automatic boot();
    bus.busy = 1'b1;
    repeat (64) tick();
    bus.busy = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!seq_idle && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, seq_idle, 1);
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.cmd_valid, 1);
  endtask

  // Called at the negedge of the ISSUE cycle of a Write command.
  task automatic wb_stream(input int nbeats, input int astep);
    tick();
    for (int i = 0; i < nbeats; i++) begin
      bus.IRAM_valid = 1'b1;
      bus.IRAM_D     = 8'(i);
      bus.IRAM_A     = 6'((i * astep) % 64);
      tick();
    end
    bus.IRAM_valid = 1'b0;
    bus.done       = 1'b1;
    tick();
    bus.done       = 1'b0;
  endtask

  // Monitor: compare every issued command against the expectation queue.
  initial begin : monitor
    bit prev_v    = 1'b0;
    bit have_prev = 1'b0;
    int idle_cnt  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v    = 1'b0;
        have_prev = 1'b0;
        idle_cnt  = 0;
      end else if (bus.cmd_valid) begin
        check("pulse_width", prev_v, 0);
        if (have_prev) check("pulse_gap", idle_cnt >= GAP_CYCLES, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL cmd_unexpected: got cmd %0d with no command pending at %0t", bus.cmd, $time);
        end else begin
          check("cmd", bus.cmd, exp_q.pop_front());
        end
        prev_v    = 1'b1;
        have_prev = 1'b1;
        idle_cnt  = 0;
      end else begin
        prev_v = 1'b0;
        idle_cnt++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.IRAM_valid = 1'b0;
    bus.IRAM_D     = 8'd0;
    bus.IRAM_A     = 6'd0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd", bus.cmd, 0);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_fifo_empty", fifo_empty, 1);
    check("rst_seq_idle", seq_idle, 0);
    check("rst_wb_count", wb_count, 0);
    check("rst_wb_sum", wb_sum, 0);
    check("rst_seq_err", seq_err, 0);
    tick();
    reset = 1'b0;
    tick();

    // Boot: busy high then low
    bus.busy = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("boot_not_idle", seq_idle, 0);
    repeat (54) tick();
    bus.busy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("boot_idle", seq_idle, 1);
    check("boot_no_valid", bus.cmd_valid, 0);

    // Latency and three plain commands
    push(4'd1, 1'b1);
    @(negedge clk);
    check("lat_first_edge", bus.cmd_valid, 0);
    @(negedge clk);
    check("lat_second_edge", bus.cmd_valid, 1);
    push(4'd3, 1'b1);
    push(4'd5, 1'b1);
    wait_idle("drain_135");
    check("empty_135", fifo_empty, 1);
    check("sb_empty_135", exp_q.size(), 0);
    check("err_135", seq_err, 0);

    // Full 64-beat write-back
    push(4'd0, 1'b1);
    wait_issue("issue_wb64");
    wb_stream(64, 1);
    @(negedge clk);
    check("wb64_count", wb_count, 64);
    check("wb64_sum", wb_sum, 2016);
    check("wb64_err", seq_err, 0);
    check("wb64_idle", seq_idle, 1);

    // Short write-back: 63 beats
    push(4'd0, 1'b1);
    wait_issue("issue_wb63");
    wb_stream(63, 1);
    @(negedge clk);
    check("wb63_count", wb_count, 63);
    check("wb63_sum", wb_sum, 1953);
    check("wb63_err", seq_err, 1);
    push(4'd7, 1'b1);
    wait_idle("drain_after_wb63");
    check("err_sticky", seq_err, 1);

    // FIFO overflow while busy
    do_reset();
    @(negedge clk);
    check("rst2_err", seq_err, 0);
    bus.busy = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < FIFO_DEPTH; i++) push(4'((i % 11) + 1), 1'b1);
    @(negedge clk);
    check("full_after_16", fifo_full, 1);
    check("err_before_17", seq_err, 0);
    push(4'd9, 1'b0);
    @(negedge clk);
    check("full_after_17", fifo_full, 1);
    check("err_after_17", seq_err, 1);
    bus.busy = 1'b0;
    wait_idle("drain_16");
    check("sb_empty_16", exp_q.size(), 0);
    check("empty_16", fifo_empty, 1);

    // Illegal code 13
    do_reset();
    boot();
    push(4'd13, 1'b0);
    @(negedge clk);
    check("code13_empty", fifo_empty, 1);
    check("code13_err", seq_err, 1);
    repeat (5) tick();
    @(negedge clk);
    check("code13_idle", seq_idle, 1);

    // Out-of-order write-back addresses
    do_reset();
    boot();
    push(4'd0, 1'b1);
    wait_issue("issue_order");
    wb_stream(64, 2);
    @(negedge clk);
    check("order_count", wb_count, 64);
    check("order_sum", wb_sum, 2016);
    check("order_err", seq_err, ORDER_ERR_EXP);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
Command initiator for the LCD image controller. It drives cmd/cmd_valid from a host-loaded command FIFO and respects the controller's busy handshake. It also monitors the IRAM write-back stream for a Write command and accumulates a beat count and byte checksum. It sits between the test/host logic and the controller's command port, in parallel with the IRAM.

Parameters:
FIFO_DEPTH, 16, command FIFO entries (power of 2, >=2)
GAP_CYCLES, 2, minimum idle cycles between two cmd_valid pulses (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
host_cmd  input  4  command code to enqueue
host_push  input  1  enqueue host_cmd this cycle
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_empty  output  1  FIFO holds 0 entries
cmd  output  4  command code to controller
cmd_valid  output  1  command strobe to controller
busy  input  1  controller busy
done  input  1  controller write-back complete
IRAM_valid  input  1  write-back beat valid
IRAM_D  input  8  write-back data
IRAM_A  input  6  write-back address
seq_idle  output  1  in IDLE with empty FIFO
wb_count  output  7  beats captured in last/current write-back
wb_sum  output  14  sum of IRAM_D over those beats, modulo 2^14
seq_err  output  1  sticky error flag

Behaviour:
- Reset values: cmd=0, cmd_valid=0, fifo_full=0, fifo_empty=1, seq_idle=0, wb_count=0, wb_sum=0, seq_err=0. FIFO is cleared and the state is BOOT. Reset mid-operation aborts everything immediately.
- FIFO: a push while full is dropped and sets seq_err. Codes 12..15 are not enqueued and set seq_err. A push and a pop in the same cycle are both honoured, including when the FIFO is full.
- Flags are registered and reflect occupancy after the current cycle's push/pop.
- States: BOOT, IDLE, ISSUE, GAP, WB.
- BOOT: waits until busy has been sampled 1 and then sampled 0 (image load finished), then goes to IDLE.
- IDLE: seq_idle=1 only when fifo_empty. If the FIFO is non-empty and busy==0, pop the head into cmd and go to ISSUE.
- ISSUE: cmd_valid=1 for exactly one cycle and cmd is held stable. Next state is WB if cmd==0, else GAP.
- GAP: cmd_valid=0 for GAP_CYCLES cycles, counted by an internal counter, then back to IDLE. cmd keeps its last value.
- WB: entering WB clears wb_count and wb_sum.
  - Each cycle with IRAM_valid=1 increments wb_count, saturating at 64, and adds IRAM_D zero-extended to wb_sum.
  - On done=1, go to IDLE. A beat in the same cycle as done is still counted.
  - On done, if wb_count (including any same-cycle beat) is not 64, set seq_err.
- seq_err clears only on reset.
- Latency: from host_push into an empty FIFO while in IDLE with busy=0, cmd_valid rises 2 cycles later (one cycle to enqueue, one to pop).

Optional Feature:
WB_ORDER_CHECK_EN
- Defined: in WB an internal expected address starts at 0. Each valid beat whose IRAM_A differs from the expected address sets seq_err. The expected address increments per beat and wraps 63->0.
- Undefined: IRAM_A is ignored and no order-check logic is built.

Test Plan:
- Reset, then busy high 64 cycles, then low -> state leaves BOOT; with the FIFO empty, seq_idle=1 and cmd_valid stays 0.
- Push 1,3,5 with busy=0 and GAP_CYCLES=2 -> three single-cycle cmd_valid pulses with cmd=1,3,5, each separated by >=2 idle cycles; FIFO empty afterwards.
- Push 0, then drive 64 beats (IRAM_D=addr, IRAM_A=0..63) followed by done -> wb_count=64, wb_sum=2016, seq_err=0, back in IDLE.
- Push 0, then drive 63 beats followed by done -> seq_err=1 and it stays 1 through later valid commands until reset.
- Hold busy=1 and push 17 commands with FIFO_DEPTH=16 -> fifo_full=1 after the 16th, the 17th is dropped, seq_err=1; releasing busy issues exactly 16 commands in order.
- Push 13 -> not enqueued, seq_err=1. With WB_ORDER_CHECK_EN, a write-back with addresses 0,2,... sets seq_err=1; without it, the same stream leaves seq_err=0 provided 64 beats arrive.
